// File: rtl/br_resolve_unit_pkg.sv
// Shared definitions for EX-stage branch resolution and the predictor update path.
package br_resolve_unit_pkg;

   localparam int unsigned BR_XLEN = 32;

   typedef enum logic [3:0] {
      COND_JIRL = 4'b0011,
      COND_B    = 4'b0100,
      COND_BL   = 4'b0101,
      COND_BEQ  = 4'b0110,
      COND_BNE  = 4'b0111,
      COND_BLT  = 4'b1000,
      COND_BGE  = 4'b1001,
      COND_BLTU = 4'b1010,
      COND_BGEU = 4'b1011
   } br_cond_e;

   typedef struct packed {
      logic [BR_XLEN-1:0] pc;
      logic [BR_XLEN-1:0] tpc;
      logic               taken;
      logic               mispred;
   } br_upd_rec_t;

endpackage

// File: rtl/br_resolve_unit_cond_eval.sv
// Per-way branch evaluator: direction, actual next PC and misprediction flag.
module br_cond_eval
   import br_resolve_unit_pkg::*;
#(
   parameter int unsigned XLEN = BR_XLEN
) (
   input  logic [3:0]      cond,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] sr1,
   input  logic [XLEN-1:0] sr2,
   input  logic            pred_taken,
   input  logic [XLEN-1:0] pred_tpc,
   output logic            taken,
   output logic [XLEN-1:0] next_pc,
   output logic            mispred
);

   logic            eq, lt, ltu;
   logic [XLEN-1:0] target;

   always_comb begin
      eq  = (sr1 == sr2);
      ltu = (sr1 < sr2);
      // differing sign bits decide the signed compare; otherwise it matches unsigned
      lt  = (sr1[XLEN-1] != sr2[XLEN-1]) ? sr1[XLEN-1] : ltu;

      case (cond)
         COND_JIRL, COND_B, COND_BL: taken = 1'b1;
         COND_BEQ:                   taken = eq;
         COND_BNE:                   taken = ~eq;
         COND_BLT:                   taken = lt;
         COND_BGE:                   taken = ~lt;
         COND_BLTU:                  taken = ltu;
         COND_BGEU:                  taken = ~ltu;
         default:                    taken = 1'b0;
      endcase

      target  = ((cond == COND_JIRL) ? sr1 : pc) + (imm << 2);
      next_pc = taken ? target : pc + XLEN'(4);
      mispred = (taken != pred_taken) | (taken & pred_taken & (pred_tpc != target));
   end

endmodule

// File: rtl/br_resolve_unit.sv
// N-way branch resolution: oldest-mispredict redirect, younger-way kill mask and
// a predictor-training FIFO drained through a valid/ready port.
module br_resolve_unit
   import br_resolve_unit_pkg::*;
#(
   parameter int unsigned N_WAYS    = 2,
   parameter int unsigned UPD_DEPTH = 4,
   parameter int unsigned XLEN      = BR_XLEN
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic                   stall,
   input  logic                   flush,
   input  logic [N_WAYS-1:0]      in_valid,
   input  logic [N_WAYS-1:0]      in_is_br,
   input  logic [4*N_WAYS-1:0]    in_cond,
   input  logic [XLEN*N_WAYS-1:0] in_pc,
   input  logic [XLEN*N_WAYS-1:0] in_imm,
   input  logic [XLEN*N_WAYS-1:0] in_sr1,
   input  logic [XLEN*N_WAYS-1:0] in_sr2,
   input  logic [N_WAYS-1:0]      in_pred_taken,
   input  logic [XLEN*N_WAYS-1:0] in_pred_tpc,
   output logic                   redirect_valid,
   output logic [XLEN-1:0]        redirect_pc,
   output logic [N_WAYS-1:0]      kill_mask,
   output logic                   upd_valid,
   input  logic                   upd_ready,
   output logic [XLEN-1:0]        upd_pc,
   output logic [XLEN-1:0]        upd_tpc,
   output logic                   upd_taken,
   output logic                   upd_mispred,
   output logic                   stall_req
);

   localparam int unsigned PTR_W = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(UPD_DEPTH + 1);

   logic [N_WAYS-1:0] acc, way_taken, way_mis;
   logic [XLEN-1:0]   way_nxt [N_WAYS];

   for (genvar k = 0; k < N_WAYS; k++) begin : g_way
      br_cond_eval #(.XLEN(XLEN)) u_eval (
         .cond       (in_cond[4*k +: 4]),
         .pc         (in_pc[XLEN*k +: XLEN]),
         .imm        (in_imm[XLEN*k +: XLEN]),
         .sr1        (in_sr1[XLEN*k +: XLEN]),
         .sr2        (in_sr2[XLEN*k +: XLEN]),
         .pred_taken (in_pred_taken[k]),
         .pred_tpc   (in_pred_tpc[XLEN*k +: XLEN]),
         .taken      (way_taken[k]),
         .next_pc    (way_nxt[k]),
         .mispred    (way_mis[k])
      );
   end

   assign acc = in_valid & in_is_br & {N_WAYS{~stall & ~flush}};

   logic              sel_found;
   logic [XLEN-1:0]   sel_pc;
   logic [N_WAYS-1:0] sel_kill, push_mask;

   // once the oldest mispredict is found, every younger way is killed and pushes nothing
   always_comb begin
      sel_found = 1'b0;
      sel_pc    = '0;
      sel_kill  = '0;
      push_mask = '0;
      for (int unsigned k = 0; k < N_WAYS; k++) begin
         if (sel_found) begin
            sel_kill[k] = 1'b1;
         end else begin
            push_mask[k] = acc[k];
            if (acc[k] & way_mis[k]) begin
               sel_found = 1'b1;
               sel_pc    = way_nxt[k];
            end
         end
      end
   end

   logic              redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
   logic [N_WAYS-1:0] kill_mask_q, kill_mask_d;

   always_comb begin
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      kill_mask_d      = kill_mask_q;
      if (flush) begin
         kill_mask_d = '0;
      end else if (!stall) begin
         redirect_valid_d = sel_found;
         kill_mask_d      = sel_kill;
         if (sel_found) redirect_pc_d = sel_pc;
      end
   end

   br_upd_rec_t      mem_q [UPD_DEPTH];
   br_upd_rec_t      mem_d [UPD_DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pop;
   int unsigned      n_push, slot;

   assign upd_valid = (cnt_q != '0);
   assign pop       = upd_valid & upd_ready;

   // pushes land contiguously after the tail in way order; pop only moves the head
   always_comb begin
      mem_d  = mem_q;
      n_push = 0;
      slot   = 0;
      for (int unsigned k = 0; k < N_WAYS; k++) begin
         if (push_mask[k]) begin
            slot = (32'(head_q) + 32'(cnt_q) + n_push) % UPD_DEPTH;
            mem_d[PTR_W'(slot)] = '{pc:      in_pc[XLEN*k +: XLEN],
                                    tpc:     way_nxt[k],
                                    taken:   way_taken[k],
                                    mispred: way_mis[k]};
            n_push = n_push + 1;
         end
      end
      head_d = pop ? PTR_W'((32'(head_q) + 32'd1) % UPD_DEPTH) : head_q;
      cnt_d  = CNT_W'(32'(cnt_q) + n_push - (pop ? 32'd1 : 32'd0));
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         kill_mask_q      <= '0;
         head_q           <= '0;
         cnt_q            <= '0;
         for (int unsigned i = 0; i < UPD_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         kill_mask_q      <= kill_mask_d;
         head_q           <= head_d;
         cnt_q            <= cnt_d;
         mem_q            <= mem_d;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign kill_mask      = kill_mask_q;
   assign upd_pc         = mem_q[head_q].pc;
   assign upd_tpc        = mem_q[head_q].tpc;
   assign upd_taken      = mem_q[head_q].taken;
   assign upd_mispred    = mem_q[head_q].mispred;
   assign stall_req      = (UPD_DEPTH - 32'(cnt_q)) < N_WAYS;

endmodule
